rating_tracker: RTL and testbench

Multi-player successor to the single-counter win/lose rating block. It keeps a saturating rating and a consecutive-win streak for each of `N_PLAYERS` players, and applies a streak bonus on wins. On a loss it either clears the rating or subtracts a penalty. It also tracks the all-time best rating and which player holds it. The block sits after the round-judging logic: it consumes one round result per cycle and drives the score display and leaderboard logic.

---
 rtl/rating_tracker.sv | 98 +++++++++
 tb/tb_rating_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rating_tracker.sv
// rating_tracker: per-player saturating ratings with win-streak bonus, loss handling and best-rating tracking.
module rating_tracker #(
  parameter int RATING_WIDTH = 8,
  parameter int N_PLAYERS = 4,
  parameter int STREAK_LEN = 3,
  parameter int BONUS_STEP = 2,
  parameter int LOSE_MODE = 0,
  parameter int LOSE_PENALTY = 1,
  localparam int PID_WIDTH = $clog2(N_PLAYERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_round_ended,
  input  logic [PID_WIDTH-1:0]              i_player_id,
  input  logic                              i_is_win,
  input  logic                              i_clear,
  output logic [N_PLAYERS*RATING_WIDTH-1:0] o_rating,
  output logic [RATING_WIDTH-1:0]           o_best_rating,
  output logic [PID_WIDTH-1:0]              o_best_player,
  output logic                              o_new_record,
  output logic [N_PLAYERS-1:0]              o_saturated,
  output logic                              o_err
);
  localparam int SW = $clog2(STREAK_LEN + 1);
  localparam logic [RATING_WIDTH-1:0] MAXR = '1;
  logic [RATING_WIDTH-1:0] r_rating [N_PLAYERS];
  logic [SW-1:0]           r_streak [N_PLAYERS];
  logic [RATING_WIDTH-1:0] r_best;
  logic [PID_WIDTH-1:0]    r_best_player;
  logic                    r_new_record;
  logic                    r_err;
  logic                    w_valid;
  logic                    w_evt;
  logic                    w_upd;
  logic                    w_rec;
  logic [RATING_WIDTH-1:0] w_cur_rating;
  logic [RATING_WIDTH-1:0] w_next_rating;
  logic [SW-1:0]           w_cur_streak;
  logic [SW-1:0]           w_next_streak;
  logic [RATING_WIDTH:0]   w_sum;
  always_comb begin
    w_valid = 1'b0;
    w_cur_rating = '0;
    w_cur_streak = '0;
    for (int k = 0; k < N_PLAYERS; k++)
      if (i_player_id == PID_WIDTH'(k)) begin
        w_valid = 1'b1;
        w_cur_rating = r_rating[k];
        w_cur_streak = r_streak[k];
      end
    // one extra bit catches overflow before clamping to full scale
    w_sum = {1'b0, w_cur_rating} + ((int'(w_cur_streak) >= STREAK_LEN - 1) ?
            (RATING_WIDTH+1)'(BONUS_STEP) : (RATING_WIDTH+1)'(1));
    w_next_rating = i_is_win ? (w_sum[RATING_WIDTH] ? MAXR : w_sum[RATING_WIDTH-1:0]) :
                    (LOSE_MODE != 0 && int'(w_cur_rating) > LOSE_PENALTY) ?
                    w_cur_rating - RATING_WIDTH'(LOSE_PENALTY) : '0;
    w_next_streak = !i_is_win ? '0 :
                    (int'(w_cur_streak) >= STREAK_LEN) ? w_cur_streak : w_cur_streak + SW'(1);
    w_evt = i_round_ended & ~i_clear;
    w_upd = w_evt & w_valid;
    w_rec = w_upd & (w_next_rating > r_best);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_PLAYERS; k++) begin
        r_rating[k] <= '0;
        r_streak[k] <= '0;
      end
      r_best <= '0;
      r_best_player <= '0;
      r_new_record <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_new_record <= w_rec;
      r_err <= w_evt & ~w_valid;
      if (w_rec) begin
        r_best <= w_next_rating;
        r_best_player <= i_player_id;
      end
      for (int k = 0; k < N_PLAYERS; k++)
        if (i_clear) begin
          r_rating[k] <= '0;
          r_streak[k] <= '0;
        end else if (w_upd && i_player_id == PID_WIDTH'(k)) begin
          r_rating[k] <= w_next_rating;
          r_streak[k] <= w_next_streak;
        end
    end
  end
  for (genvar k = 0; k < N_PLAYERS; k++) begin : g_out
    assign o_rating[k*RATING_WIDTH +: RATING_WIDTH] = r_rating[k];
    assign o_saturated[k] = (r_rating[k] == MAXR);
  end
  assign o_best_rating = r_best;
  assign o_best_player = r_best_player;
  assign o_new_record = r_new_record;
  assign o_err = r_err;
endmodule

// File: tb/tb_rating_tracker.sv
// tb_rating_tracker: drives a default instance and a W=4/N=3/penalty-mode instance with shared stimulus,
// checking both against an arithmetic reference model plus directed expectations.
module tb_rating_tracker;
  logic clk = 0;
  logic rst = 0, rnd = 0, win = 0, clr = 0;
  logic [1:0] id = 0;
  logic [31:0] ra;
  logic [7:0] best_a;
  logic [1:0] bp_a;
  logic rec_a, err_a;
  logic [3:0] sat_a;
  logic [11:0] rb;
  logic [3:0] best_b;
  logic [1:0] bp_b;
  logic rec_b, err_b;
  logic [2:0] sat_b;
  logic [63:0] obs_a, obs_b;
  int n_checks = 0, n_fails = 0;
  int p_w[2] = '{8, 4};
  int p_n[2] = '{4, 3};
  int p_lm[2] = '{0, 1};
  int p_pen[2] = '{1, 3};
  int m_rating[2][16], m_streak[2][16], m_best[2], m_bp[2], m_rec[2], m_err[2];

  always #5 clk = ~clk;

  rating_tracker u_a (
    .clk(clk), .rst(rst), .i_round_ended(rnd), .i_player_id(id), .i_is_win(win), .i_clear(clr),
    .o_rating(ra), .o_best_rating(best_a), .o_best_player(bp_a), .o_new_record(rec_a),
    .o_saturated(sat_a), .o_err(err_a));

  rating_tracker #(.RATING_WIDTH(4), .N_PLAYERS(3), .LOSE_MODE(1), .LOSE_PENALTY(3)) u_b (
    .clk(clk), .rst(rst), .i_round_ended(rnd), .i_player_id(id), .i_is_win(win), .i_clear(clr),
    .o_rating(rb), .o_best_rating(best_b), .o_best_player(bp_b), .o_new_record(rec_b),
    .o_saturated(sat_b), .o_err(err_b));

  assign obs_a = 64'({ra, best_a, bp_a, rec_a, sat_a, err_a});
  assign obs_b = 64'({rb, best_b, bp_b, rec_b, sat_b, err_b});

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int mx, p, r;
      mx = (1 << p_w[d]) - 1;
      p = int'(id);
      m_rec[d] = 0;
      m_err[d] = 0;
      if (rst) begin
        for (int k = 0; k < 16; k++) begin m_rating[d][k] = 0; m_streak[d][k] = 0; end
        m_best[d] = 0;
        m_bp[d] = 0;
      end else if (clr) begin
        for (int k = 0; k < 16; k++) begin m_rating[d][k] = 0; m_streak[d][k] = 0; end
      end else if (rnd) begin
        if (p >= p_n[d]) m_err[d] = 1;
        else begin
          if (win) begin
            r = m_rating[d][p] + ((m_streak[d][p] >= 2) ? 2 : 1);
            m_rating[d][p] = (r > mx) ? mx : r;
            m_streak[d][p] = (m_streak[d][p] >= 3) ? 3 : m_streak[d][p] + 1;
          end else begin
            r = m_rating[d][p] - p_pen[d];
            m_rating[d][p] = (p_lm[d] == 0 || r < 0) ? 0 : r;
            m_streak[d][p] = 0;
          end
          if (m_rating[d][p] > m_best[d]) begin
            m_best[d] = m_rating[d][p];
            m_bp[d] = p;
            m_rec[d] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_obs(int d);
    logic [63:0] v;
    int mx;
    v = 0;
    mx = (1 << p_w[d]) - 1;
    for (int k = p_n[d] - 1; k >= 0; k--) v = (v << p_w[d]) | 64'(m_rating[d][k]);
    v = (v << p_w[d]) | 64'(m_best[d]);
    v = (v << 2) | 64'(m_bp[d]);
    v = (v << 1) | 64'(m_rec[d]);
    for (int k = p_n[d] - 1; k >= 0; k--) v = (v << 1) | 64'(m_rating[d][k] == mx);
    v = (v << 1) | 64'(m_err[d]);
    return v;
  endfunction

  task automatic cyc(input logic r_rst, input logic r_rnd, input logic [1:0] r_id,
                     input logic r_win, input logic r_clr);
    rst = r_rst; rnd = r_rnd; id = r_id; win = r_win; clr = r_clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 2'd1, 1, 0);
      n_checks++;
      if (obs_a !== 64'd0) begin n_fails++; $display("FAIL reset_a: got %h want 0", obs_a); end
      n_checks++;
      if (obs_b !== 64'd0) begin n_fails++; $display("FAIL reset_b: got %h want 0", obs_b); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 2'd1, 1, 0);
      n_checks++;
      if (obs_a !== 64'd0 || obs_b !== 64'd0) begin
        n_fails++; $display("FAIL reset_hold: got a=%h b=%h want 0", obs_a, obs_b);
      end
    end
  endtask

  task automatic test_streak();
    int want[5] = '{1, 2, 4, 6, 8};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 2'd1, 1, 0);
      n_checks++;
      if ({ra[15:8], rec_a} !== {8'(want[i]), 1'b1}) begin
        n_fails++; $display("FAIL streak_a[%0d]: got r=%0d rec=%b want r=%0d rec=1", i, ra[15:8], rec_a, want[i]);
      end
      n_checks++;
      if (obs_b !== exp_obs(1)) begin n_fails++; $display("FAIL streak_b: got %h want %h", obs_b, exp_obs(1)); end
    end
    n_checks++;
    if ({best_a, bp_a} !== {8'd8, 2'd1}) begin
      n_fails++; $display("FAIL streak_best: got %0d/%0d want 8/1", best_a, bp_a);
    end
  endtask

  task automatic test_loss();
    int want_b[3] = '{5, 2, 0};
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'd1, 0, 0);
      n_checks++;
      if ({ra[15:8], best_a, rec_a} !== {8'd0, 8'd8, 1'b0}) begin
        n_fails++; $display("FAIL loss_a: got r=%0d best=%0d rec=%b want 0/8/0", ra[15:8], best_a, rec_a);
      end
      n_checks++;
      if (rb[7:4] !== 4'(want_b[i])) begin
        n_fails++; $display("FAIL loss_b[%0d]: got %0d want %0d", i, rb[7:4], want_b[i]);
      end
    end
    cyc(0, 1, 2'd1, 1, 0);
    n_checks++;
    if ({ra[15:8], rb[7:4]} !== {8'd1, 4'd1}) begin
      n_fails++; $display("FAIL loss_rewin: got a=%0d b=%0d want 1/1", ra[15:8], rb[7:4]);
    end
  endtask

  task automatic test_sat_tie();
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 2'd0, 1, 0);
      n_checks++;
      if (obs_a !== exp_obs(0) || obs_b !== exp_obs(1)) begin
        n_fails++; $display("FAIL sat_model: got a=%h b=%h want a=%h b=%h", obs_a, obs_b, exp_obs(0), exp_obs(1));
      end
    end
    n_checks++;
    if ({rb[3:0], sat_b[0], best_b, bp_b, rec_b} !== {4'd15, 1'b1, 4'd15, 2'd0, 1'b1}) begin
      n_fails++; $display("FAIL sat_b: got r=%0d sat=%b best=%0d bp=%0d rec=%b want 15/1/15/0/1",
                          rb[3:0], sat_b[0], best_b, bp_b, rec_b);
    end
    for (int i = 0; i < 9; i++) cyc(0, 1, 2'd2, 1, 0);
    n_checks++;
    if ({rb[11:8], sat_b, best_b, bp_b, rec_b} !== {4'd15, 3'b101, 4'd15, 2'd0, 1'b0}) begin
      n_fails++; $display("FAIL tie_b: got r=%0d sat=%b best=%0d bp=%0d rec=%b want 15/101/15/0/0",
                          rb[11:8], sat_b, best_b, bp_b, rec_b);
    end
    n_checks++;
    if (obs_a !== exp_obs(0)) begin n_fails++; $display("FAIL tie_a: got %h want %h", obs_a, exp_obs(0)); end
  endtask

  task automatic test_clear_invalid();
    cyc(0, 1, 2'd3, 1, 1);
    n_checks++;
    if ({ra, rb, rec_a, rec_b, err_b} !== 47'd0 || best_a !== 8'd16 || best_b !== 4'd15) begin
      n_fails++; $display("FAIL clear: got ra=%h rb=%h rec=%b%b err=%b best=%0d/%0d want 0,0,00,0,16/15",
                          ra, rb, rec_a, rec_b, err_b, best_a, best_b);
    end
    cyc(0, 1, 2'd3, 1, 0);
    n_checks++;
    if ({err_b, rb, err_a, ra[31:24]} !== {1'b1, 12'd0, 1'b0, 8'd1}) begin
      n_fails++; $display("FAIL invalid: got err_b=%b rb=%h err_a=%b ra3=%0d want 1/0/0/1", err_b, rb, err_a, ra[31:24]);
    end
    cyc(0, 0, 2'd3, 1, 0);
    n_checks++;
    if (err_b !== 1'b0) begin n_fails++; $display("FAIL invalid_pulse: got err_b=%b want 0", err_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 150) == 0, ($urandom % 4) != 0, 2'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
      n_checks++;
      if (obs_a !== exp_obs(0)) begin n_fails++; $display("FAIL random_a[%0d]: got %h want %h", i, obs_a, exp_obs(0)); end
      n_checks++;
      if (obs_b !== exp_obs(1)) begin n_fails++; $display("FAIL random_b[%0d]: got %h want %h", i, obs_b, exp_obs(1)); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_streak();
    test_loss();
    test_sat_tie();
    test_clear_invalid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
